// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with shift/caps tracking and an
// output character FIFO that drops (and flags) characters when full.
module kbd_ascii_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             code_valid,
    input  logic [7:0]       code,
    input  logic             ascii_ready,
    output logic             ascii_valid,
    output logic [7:0]       ascii,
    output logic             shift,
    output logic             caps,
    output logic             overflow,
    output logic [CNT_W-1:0] key_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = AW + 1;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;
    localparam logic [7:0] CODE_ENTER  = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_BREAK     = 2'd1,
        S_EXT       = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic           shift_l_q, shift_r_q;
    logic           caps_q, caps_held_q;
    logic           overflow_q;
    logic [CNT_W-1:0] key_count_q;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]  cnt_q;

    // Decode actions produced by the FSM output process
    logic           push_req;
    logic [7:0]     push_char;
    logic           set_l, clr_l, set_r, clr_r;
    logic           caps_make, caps_break;

    logic           fifo_empty, fifo_full, pop, push_ok, drop;

    // US-layout make-code lookup: {hit, character}
    function automatic logic [8:0] map_make(input logic [7:0] c,
                                            input logic sh,
                                            input logic cp);
        logic       hit;
        logic       letter;
        logic [7:0] lo;
        logic [7:0] alt;
        logic [7:0] ch;
        hit    = 1'b1;
        letter = 1'b0;
        lo     = 8'h00;
        alt    = 8'h00;
        case (c)
            8'h1C: begin letter = 1'b1; lo = 8'h61; end
            8'h32: begin letter = 1'b1; lo = 8'h62; end
            8'h21: begin letter = 1'b1; lo = 8'h63; end
            8'h23: begin letter = 1'b1; lo = 8'h64; end
            8'h24: begin letter = 1'b1; lo = 8'h65; end
            8'h2B: begin letter = 1'b1; lo = 8'h66; end
            8'h34: begin letter = 1'b1; lo = 8'h67; end
            8'h33: begin letter = 1'b1; lo = 8'h68; end
            8'h43: begin letter = 1'b1; lo = 8'h69; end
            8'h3B: begin letter = 1'b1; lo = 8'h6A; end
            8'h42: begin letter = 1'b1; lo = 8'h6B; end
            8'h4B: begin letter = 1'b1; lo = 8'h6C; end
            8'h3A: begin letter = 1'b1; lo = 8'h6D; end
            8'h31: begin letter = 1'b1; lo = 8'h6E; end
            8'h44: begin letter = 1'b1; lo = 8'h6F; end
            8'h4D: begin letter = 1'b1; lo = 8'h70; end
            8'h15: begin letter = 1'b1; lo = 8'h71; end
            8'h2D: begin letter = 1'b1; lo = 8'h72; end
            8'h1B: begin letter = 1'b1; lo = 8'h73; end
            8'h2C: begin letter = 1'b1; lo = 8'h74; end
            8'h3C: begin letter = 1'b1; lo = 8'h75; end
            8'h2A: begin letter = 1'b1; lo = 8'h76; end
            8'h1D: begin letter = 1'b1; lo = 8'h77; end
            8'h22: begin letter = 1'b1; lo = 8'h78; end
            8'h35: begin letter = 1'b1; lo = 8'h79; end
            8'h1A: begin letter = 1'b1; lo = 8'h7A; end
            8'h0E: begin lo = 8'h60; alt = 8'h7E; end
            8'h16: begin lo = 8'h31; alt = 8'h21; end
            8'h1E: begin lo = 8'h32; alt = 8'h40; end
            8'h26: begin lo = 8'h33; alt = 8'h23; end
            8'h25: begin lo = 8'h34; alt = 8'h24; end
            8'h2E: begin lo = 8'h35; alt = 8'h25; end
            8'h36: begin lo = 8'h36; alt = 8'h5E; end
            8'h3D: begin lo = 8'h37; alt = 8'h26; end
            8'h3E: begin lo = 8'h38; alt = 8'h2A; end
            8'h46: begin lo = 8'h39; alt = 8'h28; end
            8'h45: begin lo = 8'h30; alt = 8'h29; end
            8'h4E: begin lo = 8'h2D; alt = 8'h5F; end
            8'h55: begin lo = 8'h3D; alt = 8'h2B; end
            8'h54: begin lo = 8'h5B; alt = 8'h7B; end
            8'h5B: begin lo = 8'h5D; alt = 8'h7D; end
            8'h5D: begin lo = 8'h5C; alt = 8'h7C; end
            8'h4C: begin lo = 8'h3B; alt = 8'h3A; end
            8'h52: begin lo = 8'h27; alt = 8'h22; end
            8'h41: begin lo = 8'h2C; alt = 8'h3C; end
            8'h49: begin lo = 8'h2E; alt = 8'h3E; end
            8'h4A: begin lo = 8'h2F; alt = 8'h3F; end
            8'h5A: begin lo = 8'h0D; alt = 8'h0D; end
            8'h29: begin lo = 8'h20; alt = 8'h20; end
            8'h66: begin lo = 8'h08; alt = 8'h08; end
            8'h0D: begin lo = 8'h09; alt = 8'h09; end
            default: hit = 1'b0;
        endcase
        if (letter) begin
            ch = (sh ^ cp) ? (lo - 8'h20) : lo;
        end else begin
            ch = sh ? alt : lo;
        end
        return {hit, ch};
    endfunction

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; prefixes F0/E0 only move the FSM on valid bytes
    always_comb begin
        state_d = state_q;
        if (code_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (code == CODE_BREAK) begin
                        state_d = S_BREAK;
                    end else if (code == CODE_EXT) begin
                        state_d = S_EXT;
                    end
                end
                S_BREAK:     state_d = S_IDLE;
                S_EXT:       state_d = (code == CODE_BREAK) ? S_EXT_BREAK : S_IDLE;
                S_EXT_BREAK: state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Output/action logic
    always_comb begin
        push_req   = 1'b0;
        push_char  = 8'h00;
        set_l      = 1'b0;
        clr_l      = 1'b0;
        set_r      = 1'b0;
        clr_r      = 1'b0;
        caps_make  = 1'b0;
        caps_break = 1'b0;
        if (code_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (code != CODE_BREAK && code != CODE_EXT) begin
                        case (code)
                            CODE_LSHIFT: set_l     = 1'b1;
                            CODE_RSHIFT: set_r     = 1'b1;
                            CODE_CAPS:   caps_make = 1'b1;
                            default: {push_req, push_char} = map_make(code, shift, caps_q);
                        endcase
                    end
                end
                S_BREAK: begin
                    clr_l      = (code == CODE_LSHIFT);
                    clr_r      = (code == CODE_RSHIFT);
                    caps_break = (code == CODE_CAPS);
                end
                S_EXT: begin
                    if (code == CODE_ENTER) begin
                        push_req  = 1'b1;
                        push_char = 8'h0D;
                    end
                end
                default: ;
            endcase
        end
    end

    // Modifier state
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            if (set_l)      shift_l_q <= 1'b1;
            else if (clr_l) shift_l_q <= 1'b0;
            if (set_r)      shift_r_q <= 1'b1;
            else if (clr_r) shift_r_q <= 1'b0;
            // Typematic repeats keep caps_held set, so only the first make toggles
            if (caps_make) begin
                if (!caps_held_q) caps_q <= ~caps_q;
                caps_held_q <= 1'b1;
            end else if (caps_break) begin
                caps_held_q <= 1'b0;
            end
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == OW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && ascii_ready;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    // FIFO storage; when full with a simultaneous pop the write lands in the slot being freed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_char;
        end
    end

    // FIFO pointers, occupancy and statistics
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            key_count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q    <= wr_ptr_q + AW'(1);
                key_count_q <= key_count_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + OW'(1);
                2'b01:   cnt_q <= cnt_q - OW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign ascii_valid = !fifo_empty;
    assign ascii       = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign shift       = shift_l_q | shift_r_q;
    assign caps        = caps_q;
    assign overflow    = overflow_q;
    assign key_count   = key_count_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Randomised self-checking bench for kbd_ascii_decoder against a queue-based
// behavioural keyboard model, plus directed scenarios with literal expectations.
module tb_kbd_ascii_decoder;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic          clk;
    logic          clrn;
    logic          code_valid;
    logic [7:0]    code;
    logic          ascii_ready;
    logic          ascii_valid;
    logic [7:0]    ascii;
    logic          shift;
    logic          caps;
    logic          overflow;
    logic [CW-1:0] key_count;

    kbd_ascii_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .code_valid  (code_valid),
        .code        (code),
        .ascii_ready (ascii_ready),
        .ascii_valid (ascii_valid),
        .ascii       (ascii),
        .shift       (shift),
        .caps        (caps),
        .overflow    (overflow),
        .key_count   (key_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] q[$];
    int         prefix;      // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    bit         lsh, rsh, cp, cheld, ovf;
    int         kc;
    int         lo_map [256];
    int         hi_map [256];
    bit         is_let [256];

    logic [7:0] dut_pops[$];
    int         valid_cycles;
    int         checks;
    int         failures;
    int         cyc;

    function automatic void build_maps();
        logic [7:0] lc [26];
        logic [7:0] dc [10];
        logic [7:0] pc [10];
        logic [7:0] dlo [10];
        logic [7:0] dhi [10];
        logic [7:0] plo [10];
        logic [7:0] phi [10];
        lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
               8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
               8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        dc = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
        pc = '{8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
        dlo = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30};
        dhi = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29};
        plo = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
        phi = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
        for (int i = 0; i < 256; i++) begin
            lo_map[i] = -1;
            hi_map[i] = -1;
            is_let[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            is_let[lc[i]] = 1'b1;
            lo_map[lc[i]] = 97 + i;
            hi_map[lc[i]] = 65 + i;
        end
        for (int i = 0; i < 10; i++) begin
            lo_map[dc[i]] = int'(dlo[i]);
            hi_map[dc[i]] = int'(dhi[i]);
            lo_map[pc[i]] = int'(plo[i]);
            hi_map[pc[i]] = int'(phi[i]);
        end
        lo_map[8'h0E] = 8'h60; hi_map[8'h0E] = 8'h7E;
        lo_map[8'h5A] = 8'h0D; hi_map[8'h5A] = 8'h0D;
        lo_map[8'h29] = 8'h20; hi_map[8'h29] = 8'h20;
        lo_map[8'h66] = 8'h08; hi_map[8'h66] = 8'h08;
        lo_map[8'h0D] = 8'h09; hi_map[8'h0D] = 8'h09;
    endfunction

    function automatic void model_reset();
        q.delete();
        prefix = 0;
        lsh = 0; rsh = 0; cp = 0; cheld = 0; ovf = 0;
        kc = 0;
    endfunction

    // One clock edge of the keyboard model with the inputs present at that edge
    function automatic void model_edge(bit v, logic [7:0] c, bit r);
        int         sz;
        bit         do_pop, do_push, sh;
        logic [7:0] ch;
        sz      = q.size();
        do_pop  = (sz > 0) && r;
        do_push = 0;
        ch      = 8'h00;
        sh      = lsh | rsh;
        if (v) begin
            if (prefix == 1) begin
                if (c == 8'h12) lsh = 0;
                if (c == 8'h59) rsh = 0;
                if (c == 8'h58) cheld = 0;
                prefix = 0;
            end else if (prefix == 2) begin
                if (c == 8'hF0) prefix = 3;
                else begin
                    if (c == 8'h5A) begin do_push = 1; ch = 8'h0D; end
                    prefix = 0;
                end
            end else if (prefix == 3) begin
                prefix = 0;
            end else if (c == 8'hF0) prefix = 1;
            else if (c == 8'hE0) prefix = 2;
            else if (c == 8'h12) lsh = 1;
            else if (c == 8'h59) rsh = 1;
            else if (c == 8'h58) begin
                if (!cheld) cp = !cp;
                cheld = 1;
            end else if (lo_map[c] >= 0) begin
                do_push = 1;
                if (is_let[c]) ch = 8'((sh ^ cp) ? hi_map[c] : lo_map[c]);
                else           ch = 8'(sh ? hi_map[c] : lo_map[c]);
            end
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            if (sz == DEPTH && !do_pop) ovf = 1;
            else begin
                q.push_back(ch);
                kc = (kc + 1) % (1 << CW);
            end
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        check("ascii_valid", int'(ascii_valid), (q.size() > 0) ? 1 : 0);
        check("ascii", int'(ascii), (q.size() > 0) ? int'(q[0]) : 0);
        check("shift", int'(shift), int'(lsh | rsh));
        check("caps", int'(caps), int'(cp));
        check("overflow", int'(overflow), int'(ovf));
        check("key_count", int'(key_count), kc);
    endtask

    // Entered and left at posedge+1
    task automatic step(input logic v, input logic [7:0] c, input logic r);
        code_valid  = v;
        code        = c;
        ascii_ready = r;
        @(negedge clk);
        if (ascii_valid) valid_cycles++;
        if (ascii_valid && ascii_ready) dut_pops.push_back(ascii);
        @(posedge clk);
        cyc++;
        model_edge(v, c, r);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        clrn       = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        #1;
        clrn = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_pops(input string name, input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input int n);
        logic [7:0] exp [3];
        exp = '{e0, e1, e2};
        check({name, "_count"}, dut_pops.size(), n);
        for (int i = 0; i < n; i++) begin
            check({name, "_char"}, (i < dut_pops.size()) ? int'(dut_pops[i]) : -1, int'(exp[i]));
        end
    endtask

    initial begin
        int rdy_pct;
        int sel;
        logic [7:0] c;
        logic [7:0] letters [6];
        checks = 0; failures = 0; cyc = 0; valid_cycles = 0;
        clrn = 1'b0; code_valid = 1'b0; code = 8'h00; ascii_ready = 1'b0;
        build_maps();
        model_reset();
        #3;
        compare_all();
        check("reset_ascii_lit", int'(ascii), 0);
        @(posedge clk);
        #1;
        clrn = 1'b1;

        // Single key press and release
        dut_pops.delete(); valid_cycles = 0;
        step(1, 8'h1C, 1); step(1, 8'hF0, 1); step(1, 8'h1C, 1); idle(2);
        check_pops("single_a", 8'h61, 8'h00, 8'h00, 1);
        check("single_valid_cycles", valid_cycles, 1);
        check("single_key_count", int'(key_count), 1);

        // Shifted letter and digit
        do_reset(); dut_pops.delete();
        step(1, 8'h12, 1);
        check("shift_held", int'(shift), 1);
        step(1, 8'h1C, 1); step(1, 8'h16, 1); step(1, 8'hF0, 1); step(1, 8'h12, 1);
        check("shift_released", int'(shift), 0);
        step(1, 8'h1C, 1); idle(2);
        check_pops("shift_seq", 8'h41, 8'h21, 8'h61, 3);

        // Caps toggling ignores typematic repeats
        do_reset(); dut_pops.delete();
        step(1, 8'h58, 1);
        check("caps_on", int'(caps), 1);
        step(1, 8'h58, 1); step(1, 8'h58, 1);
        check("caps_repeat", int'(caps), 1);
        step(1, 8'hF0, 1); step(1, 8'h58, 1); step(1, 8'h1C, 1); step(1, 8'h16, 1); idle(2);
        check_pops("caps_seq", 8'h41, 8'h31, 8'h00, 2);
        step(1, 8'h58, 1); step(1, 8'hF0, 1); step(1, 8'h58, 1);
        check("caps_off", int'(caps), 0);

        // Overflow then simultaneous push and pop while full
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) step(1, 8'h1C, 0);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_key_count", int'(key_count), 8);
        dut_pops.delete();
        step(1, 8'h1C, 1);
        check("full_pushpop_count", int'(key_count), 9);
        idle(DEPTH + 2);
        check("drain_count", dut_pops.size(), 9);
        check("ovf_sticky", int'(overflow), 1);

        // Extended codes: only keypad Enter pushes
        do_reset(); dut_pops.delete();
        step(1, 8'hE0, 1); step(1, 8'h5A, 1);
        step(1, 8'hE0, 1); step(1, 8'hF0, 1); step(1, 8'h5A, 1);
        step(1, 8'hE0, 1); step(1, 8'h75, 1);
        step(1, 8'h1C, 1); idle(2);
        check_pops("ext_seq", 8'h0D, 8'h61, 8'h00, 2);

        // Reset discards a partial sequence and held shift
        do_reset(); dut_pops.delete();
        step(1, 8'h12, 1); step(1, 8'hE0, 1);
        do_reset();
        step(1, 8'h1C, 1); idle(2);
        check_pops("reset_mid", 8'h61, 8'h00, 8'h00, 1);

        // Randomised traffic
        letters = '{8'h1C, 8'h32, 8'h16, 8'h4E, 8'h29, 8'h41};
        do_reset();
        rdy_pct = 50;
        for (int i = 0; i < 5000; i++) begin
            if (i % 250 == 0) rdy_pct = (($urandom_range(0, 2)) == 0) ? 10 :
                                        (($urandom_range(0, 1)) == 0) ? 50 : 95;
            if ($urandom_range(0, 399) == 0) do_reset();
            sel = $urandom_range(0, 11);
            case (sel)
                0:       c = 8'hF0;
                1:       c = 8'hE0;
                2:       c = 8'h12;
                3:       c = 8'h59;
                4:       c = 8'h58;
                5:       c = 8'h5A;
                6, 7:    c = 8'($urandom_range(0, 255));
                default: c = letters[$urandom_range(0, 5)];
            endcase
            step(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 99) < rdy_pct));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
